multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/core0_pkg.sv | 31 +++
 rtl/alu_decoder.sv | 16 +
 rtl/multicycle_controller.sv | 120 ++++++++++++
 tb/tb_multicycle_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/core0_pkg.sv
// core0_pkg: shared state, opcode and datapath-select encodings for the multicycle core.
package core0_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_ALUWB, S_BEQ, S_HALT
  } state_t;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_BAD = 3'b111;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's ALU operation class plus func3/func7[5] to alu_ctrl.
module alu_decoder
  import core0_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic       func7_5,
  output logic [2:0] alu_ctrl
);
  logic [2:0] r_ctrl;
  assign r_ctrl = (func3 == 3'b000) ? (func7_5 ? ALU_SUB : ALU_ADD) :
                  (func3 == 3'b111) ? ALU_AND :
                  (func3 == 3'b110) ? ALU_OR  : ALU_BAD;
  assign alu_ctrl = (alu_op == ALUOP_R)   ? r_ctrl :
                    (alu_op == ALUOP_SUB) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: load/store/R-type/beq multicycle control FSM with illegal-op halt.
module multicycle_controller
  import core0_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       halted
);
  state_t state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] dec_ctrl;
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};
  alu_decoder u_alu_decoder (
    .alu_op  (alu_op),
    .func3   (func3),
    .func7_5 (func7[5]),
    .alu_ctrl(dec_ctrl)
  );
  // Decoder output is gated too, so every output reads 0 while reset is held.
  assign alu_ctrl = rst_n ? dec_ctrl : ALU_ADD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    result_src = RES_ALUOUT;
    retire     = 1'b0;
    halted     = 1'b0;
    alu_op     = ALUOP_ADD;
    if (rst_n)
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          state_d    = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
          state_d   = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
                      (op == OP_RTYPE) ? S_EXECUTER :
                      (op == OP_BEQ)   ? S_BEQ : S_HALT;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
          state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          state_d = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          retire    = mem_ready;
          state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECUTER: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_R;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          pc_write  = alu_zero;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle scoreboard of all controller outputs.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, pc_write, ir_write, reg_write, retire, halted;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_ctrl;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string      n;
    logic [18:0] v;
  } exp_t;
  exp_t q[$];
  // Packing: mreq,mwr,adr,pcw,irw,rw,srcA[2],srcB[2],ctrl[3],imm[2],res[2],retire,halted
  localparam logic [18:0] RST = '0;
  localparam logic [18:0] F0  = {6'b100000, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [18:0] F1  = {6'b100110, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00};
  localparam logic [18:0] DEC = {6'b000000, 2'b01, 2'b01, 3'b000, 2'b10, 2'b00, 2'b00};
  localparam logic [18:0] MAL = {6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MAS = {6'b000000, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00, 2'b00};
  localparam logic [18:0] MR  = {6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MWB = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 2'b10};
  localparam logic [18:0] MW0 = {6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MW1 = {6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] EXA = {6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] EXS = {6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] EXN = {6'b000000, 2'b10, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] EXO = {6'b000000, 2'b10, 2'b00, 3'b011, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] EXI = {6'b000000, 2'b10, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] AWB = {6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] BQ1 = {6'b000100, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] BQ0 = {6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] HLT = {6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01};

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
    .result_src(result_src), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] outs();
    return {mem_req, mem_write, adr_src, pc_write, ir_write, reg_write,
            alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, retire, halted};
  endfunction

  task automatic check(input string n, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.n, outs(), e.v);
    end

  task automatic cyc(input logic mr, input logic az, input string n, input logic [18:0] e);
    exp_t x;
    mem_ready = mr;
    alu_zero = az;
    x.n = n;
    x.v = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op = o;
    func3 = f3;
    func7 = f7;
  endtask

  task automatic rtype(input logic [2:0] f3, input logic [6:0] f7, input string n, input logic [18:0] ex);
    ins(7'b0110011, f3, f7);
    cyc(1, 0, {n, "_fetch"}, F1);
    cyc(0, 0, {n, "_decode"}, DEC);
    cyc(1, 0, {n, "_exec"}, ex);
    cyc(0, 0, {n, "_aluwb"}, AWB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    cyc(1, 0, "reset_hold0", RST);
    cyc(1, 0, "reset_hold1", RST);
    rst_n = 1'b1;
    ins(7'b0000011, 3'b010, 7'b0);
    cyc(0, 0, "ld_fetch_w0", F0);
    cyc(0, 0, "ld_fetch_w1", F0);
    cyc(1, 0, "ld_fetch", F1);
    cyc(1, 0, "ld_decode", DEC);
    cyc(1, 0, "ld_memadr", MAL);
    cyc(0, 0, "ld_memread_w0", MR);
    cyc(0, 0, "ld_memread_w1", MR);
    cyc(1, 0, "ld_memread", MR);
    cyc(0, 0, "ld_memwb", MWB);
    ins(7'b0100011, 3'b010, 7'b0);
    cyc(1, 0, "st_fetch", F1);
    cyc(0, 0, "st_decode", DEC);
    cyc(0, 0, "st_memadr", MAS);
    cyc(1, 0, "st_memwrite", MW1);
    cyc(1, 0, "st2_fetch", F1);
    cyc(0, 0, "st2_decode", DEC);
    cyc(1, 0, "st2_memadr", MAS);
    cyc(0, 0, "st2_memwrite_w", MW0);
    cyc(1, 0, "st2_memwrite", MW1);
    rtype(3'b000, 7'b0100000, "sub", EXS);
    rtype(3'b000, 7'b0000000, "add", EXA);
    rtype(3'b111, 7'b0000000, "and", EXN);
    rtype(3'b110, 7'b0000000, "or", EXO);
    rtype(3'b001, 7'b0000000, "inv", EXI);
    ins(7'b1100011, 3'b000, 7'b0);
    cyc(1, 0, "beq1_fetch", F1);
    cyc(0, 0, "beq1_decode", DEC);
    cyc(0, 1, "beq_taken", BQ1);
    cyc(1, 0, "beq0_fetch", F1);
    cyc(0, 1, "beq0_decode", DEC);
    cyc(1, 0, "beq_not_taken", BQ0);
    ins(7'b0000011, 3'b010, 7'b0);
    cyc(1, 0, "rst_fetch", F1);
    cyc(0, 0, "rst_decode", DEC);
    cyc(0, 0, "rst_memadr", MAL);
    cyc(0, 0, "rst_memread_w", MR);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", outs(), RST);
    @(posedge clk);
    #1;
    cyc(0, 0, "rst_hold", RST);
    rst_n = 1'b1;
    cyc(0, 0, "rst_restart_fetch", F0);
    cyc(1, 0, "rst_fetch2", F1);
    cyc(0, 0, "rst_decode2", DEC);
    cyc(0, 0, "rst_memadr2", MAL);
    cyc(1, 0, "rst_memread2", MR);
    cyc(0, 0, "rst_memwb2", MWB);
    ins(7'b1111111, 3'b000, 7'b0);
    cyc(1, 0, "ill_fetch", F1);
    cyc(1, 0, "ill_decode", DEC);
    for (int i = 0; i < 20; i++) cyc(1'($urandom_range(1)), 1'($urandom_range(1)), "halt", HLT);
    rst_n = 1'b0;
    cyc(0, 0, "halt_reset", RST);
    rst_n = 1'b1;
    rtype(3'b000, 7'b0100000, "post_halt", EXS);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
